// File: rtl/mem_wb_pipe_if.sv
// MEM->WB beat bundle: valid/ready handshake plus NUM_CH write-back channels.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 2
);
  logic                     valid;
  logic                     ready;
  logic [NUM_CH*ADDR_W-1:0] wd;
  logic [NUM_CH-1:0]        wreg;
  logic [NUM_CH*DATA_W-1:0] wdata;

  modport master (output valid, output wd, output wreg, output wdata, input ready);
  modport slave  (input valid, input wd, input wreg, input wdata, output ready);
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage with 2-entry skid buffer, flush and write-conflict filtering.
// Optional statistics counters enabled by defining MEMWB_STATS_EN.
module mem_wb_pipe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_CH    = 2,
  parameter bit ZERO_DROP = 1'b1
`ifdef MEMWB_STATS_EN
  , parameter int CNT_W   = 32
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  mem_wb_pipe_if.slave  mem_if,
  mem_wb_pipe_if.master wb_if
`ifdef MEMWB_STATS_EN
  , output logic [CNT_W-1:0] stat_retired_o,
  output logic [CNT_W-1:0] stat_stall_o
`endif
);

  // encoding is {main_v, skid_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e                   state_q;
  logic                     wb_valid_q;
  logic                     mem_ready_q;
  logic [NUM_CH*ADDR_W-1:0] main_wd_q,    skid_wd_q;
  logic [NUM_CH-1:0]        main_wreg_q,  skid_wreg_q;
  logic [NUM_CH*DATA_W-1:0] main_wdata_q, skid_wdata_q;
  logic [NUM_CH-1:0]        cap_wreg_d;
  logic                     accept;
  logic                     deliver;

  assign accept  = mem_if.valid && mem_ready_q;
  assign deliver = wb_valid_q && wb_if.ready;

  // Younger (higher-index) channel wins a same-address conflict.
  always_comb begin
    cap_wreg_d = mem_if.wreg;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ZERO_DROP && (mem_if.wd[c*ADDR_W +: ADDR_W] == '0))
        cap_wreg_d[c] = 1'b0;
      for (int k = c + 1; k < NUM_CH; k++) begin
        if (mem_if.wreg[c] && mem_if.wreg[k] &&
            (mem_if.wd[c*ADDR_W +: ADDR_W] == mem_if.wd[k*ADDR_W +: ADDR_W]))
          cap_wreg_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      wb_valid_q   <= 1'b0;
      mem_ready_q  <= 1'b1;
      main_wd_q    <= '0;
      main_wreg_q  <= '0;
      main_wdata_q <= '0;
      skid_wd_q    <= '0;
      skid_wreg_q  <= '0;
      skid_wdata_q <= '0;
    end else if (flush_i) begin
      state_q     <= EMPTY;
      wb_valid_q  <= 1'b0;
      mem_ready_q <= 1'b1;
      main_wreg_q <= '0;
      skid_wreg_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_wd_q    <= mem_if.wd;
            main_wreg_q  <= cap_wreg_d;
            main_wdata_q <= mem_if.wdata;
            state_q      <= ONE;
            wb_valid_q   <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_wd_q    <= mem_if.wd;
            main_wreg_q  <= cap_wreg_d;
            main_wdata_q <= mem_if.wdata;
          end else if (accept) begin
            skid_wd_q    <= mem_if.wd;
            skid_wreg_q  <= cap_wreg_d;
            skid_wdata_q <= mem_if.wdata;
            state_q      <= FULL;
            mem_ready_q  <= 1'b0;
          end else if (deliver) begin
            state_q    <= EMPTY;
            wb_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (deliver) begin
            main_wd_q    <= skid_wd_q;
            main_wreg_q  <= skid_wreg_q;
            main_wdata_q <= skid_wdata_q;
            state_q      <= ONE;
            mem_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          wb_valid_q  <= 1'b0;
          mem_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_if.ready = mem_ready_q;
  assign wb_if.valid  = wb_valid_q;
  assign wb_if.wd     = main_wd_q;
  assign wb_if.wreg   = main_wreg_q & {NUM_CH{wb_valid_q}};
  assign wb_if.wdata  = main_wdata_q;

`ifdef MEMWB_STATS_EN
  logic [CNT_W-1:0] stat_retired_q;
  logic [CNT_W-1:0] stat_stall_q;

  // Flush is not cleared here: counters track lifetime activity since reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_retired_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      if (deliver && !flush_i && !(&stat_retired_q))
        stat_retired_q <= stat_retired_q + CNT_W'(1);
      if (wb_valid_q && !wb_if.ready && !(&stat_stall_q))
        stat_stall_q <= stat_stall_q + CNT_W'(1);
    end
  end

  assign stat_retired_o = stat_retired_q;
  assign stat_stall_o   = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe (2 channels); stats scenario when MEMWB_STATS_EN is defined.
module tb_mem_wb_pipe;

  typedef struct {
    logic [9:0]  wd;
    logic [1:0]  wreg;
    logic [63:0] wdata;
  } beat_t;

  logic clk;
  logic rst;
  logic flush;
  int   tests_run;
  int   tests_failed;
  beat_t sb_q[$];

  mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5), .NUM_CH(2)) mem_if ();
  mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5), .NUM_CH(2)) wb_if ();

`ifdef MEMWB_STATS_EN
  logic [3:0] stat_retired;
  logic [3:0] stat_stall;
`endif

  mem_wb_pipe #(
    .DATA_W(32), .ADDR_W(5), .NUM_CH(2), .ZERO_DROP(1'b1)
`ifdef MEMWB_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .mem_if  (mem_if),
    .wb_if   (wb_if)
`ifdef MEMWB_STATS_EN
    , .stat_retired_o (stat_retired),
    .stat_stall_o     (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_wreg(input logic [9:0] wd, input logic [1:0] wr);
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] r;
    a = wd[4:0];
    b = wd[9:5];
    r[1] = wr[1] && (b != 5'd0);
    r[0] = wr[0] && (a != 5'd0) && !(wr[1] && (a == b));
    return r;
  endfunction

  // Inputs are stable between posedge+1 and the next posedge, so negedge sees the cycle's handshake.
  always @(negedge clk) begin
    beat_t exp;
    beat_t nb;
    if (!rst || flush) begin
      sb_q.delete();
    end else begin
      if (wb_if.valid && wb_if.ready) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: got wd=%h wreg=%b wdata=%h, required no beat",
                   wb_if.wd, wb_if.wreg, wb_if.wdata);
        end else begin
          exp = sb_q.pop_front();
          if ({wb_if.wd, wb_if.wreg, wb_if.wdata} !== {exp.wd, exp.wreg, exp.wdata}) begin
            tests_failed++;
            $display("FAIL sb_beat: got wd=%h wreg=%b wdata=%h, required wd=%h wreg=%b wdata=%h",
                     wb_if.wd, wb_if.wreg, wb_if.wdata, exp.wd, exp.wreg, exp.wdata);
          end
        end
      end
      if (mem_if.valid && mem_if.ready) begin
        nb.wd    = mem_if.wd;
        nb.wreg  = exp_wreg(mem_if.wd, mem_if.wreg);
        nb.wdata = mem_if.wdata;
        sb_q.push_back(nb);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] wd0, input logic w0, input logic [31:0] d0,
                       input logic [4:0] wd1, input logic w1, input logic [31:0] d1);
    mem_if.valid = v;
    mem_if.wd    = {wd1, wd0};
    mem_if.wreg  = {w1, w0};
    mem_if.wdata = {d1, d0};
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    wb_if.ready = 1'b0;
    idle();
    #2 rst = 1'b0;
    step();
    step();
    tests_run++;
    if ({wb_if.valid, wb_if.wreg, mem_if.ready, wb_if.wdata, wb_if.wd} !== {1'b0, 2'b00, 1'b1, 64'd0, 10'd0}) begin
      tests_failed++;
      $display("FAIL reset_held: got valid=%b wreg=%b ready=%b wdata=%h wd=%h, required 0 00 1 0 0",
               wb_if.valid, wb_if.wreg, mem_if.ready, wb_if.wdata, wb_if.wd);
    end
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if ({wb_if.valid, wb_if.wreg, mem_if.ready, wb_if.wdata} !== {1'b0, 2'b00, 1'b1, 64'd0}) begin
      tests_failed++;
      $display("FAIL reset_released: got valid=%b wreg=%b ready=%b wdata=%h, required 0 00 1 0",
               wb_if.valid, wb_if.wreg, mem_if.ready, wb_if.wdata);
    end
  endtask

  task automatic test_basic();
    wb_if.ready = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 32'hA5A5_0001, 5'd0, 1'b0, 32'd0);
    step();
    idle();
    tests_run++;
    if ({wb_if.valid, wb_if.wd[4:0], wb_if.wreg, wb_if.wdata[31:0]} !== {1'b1, 5'd3, 2'b01, 32'hA5A5_0001}) begin
      tests_failed++;
      $display("FAIL basic_latency: got valid=%b wd0=%0d wreg=%b data0=%h, required 1 3 01 a5a50001",
               wb_if.valid, wb_if.wd[4:0], wb_if.wreg, wb_if.wdata[31:0]);
    end
    step();
    check_drained("basic");
  endtask

  task automatic test_back_to_back();
    int bubbles;
    bubbles = 0;
    wb_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i + 1), 1'b1, $urandom, 5'(i + 9), 1'b1, $urandom);
      step();
      if (wb_if.valid !== 1'b1) bubbles++;
    end
    idle();
    tests_run++;
    if (bubbles != 0) begin
      tests_failed++;
      $display("FAIL b2b_bubbles: got %0d bubble cycles, required 0", bubbles);
    end
    step();
    tests_run++;
    if (wb_if.valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_empty: got valid=%b, required 0", wb_if.valid);
    end
    check_drained("b2b");
  endtask

  task automatic test_stall();
    logic [31:0] d1;
    int unstable;
    unstable = 0;
    d1 = 32'h1111_0001;
    wb_if.ready = 1'b0;
    drive(1'b1, 5'd4, 1'b1, d1, 5'd5, 1'b1, 32'h2222_0001);
    step();
    drive(1'b1, 5'd6, 1'b1, 32'h1111_0002, 5'd8, 1'b0, 32'h2222_0002);
    step();
    idle();
    tests_run++;
    if (mem_if.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_full_ready: got mem_ready=%b, required 0", mem_if.ready);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (wb_if.wdata[31:0] !== d1 || wb_if.valid !== 1'b1) unstable++;
    end
    tests_run++;
    if (unstable != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d unstable cycles, required 0", unstable);
    end
    wb_if.ready = 1'b1;
    step();
    step();
    tests_run++;
    if ({wb_if.valid, mem_if.ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL stall_release: got valid=%b mem_ready=%b, required 0 1", wb_if.valid, mem_if.ready);
    end
    check_drained("stall");
  endtask

  task automatic test_conflict();
    wb_if.ready = 1'b1;
    drive(1'b1, 5'd7, 1'b1, 32'hC0, 5'd7, 1'b1, 32'hC1);
    step();
    drive(1'b1, 5'd0, 1'b1, 32'hD0, 5'd9, 1'b0, 32'hD1);
    tests_run++;
    if (wb_if.wreg !== 2'b10) begin
      tests_failed++;
      $display("FAIL conflict_same_wd: got wreg=%b, required 10", wb_if.wreg);
    end
    step();
    drive(1'b1, 5'd5, 1'b1, 32'hE0, 5'd0, 1'b1, 32'hE1);
    tests_run++;
    if (wb_if.wreg !== 2'b00) begin
      tests_failed++;
      $display("FAIL conflict_zero_drop: got wreg=%b, required 00", wb_if.wreg);
    end
    step();
    drive(1'b1, 5'd12, 1'b1, 32'hF0, 5'd12, 1'b0, 32'hF1);
    tests_run++;
    if (wb_if.wreg !== 2'b01) begin
      tests_failed++;
      $display("FAIL conflict_ch1_zero: got wreg=%b, required 01", wb_if.wreg);
    end
    step();
    idle();
    tests_run++;
    if (wb_if.wreg !== 2'b01) begin
      tests_failed++;
      $display("FAIL conflict_one_enabled: got wreg=%b, required 01", wb_if.wreg);
    end
    step();
    tests_run++;
    if (wb_if.wreg !== 2'b00) begin
      tests_failed++;
      $display("FAIL conflict_idle_wreg: got wreg=%b, required 00", wb_if.wreg);
    end
    check_drained("conflict");
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    wb_if.ready = 1'b0;
    drive(1'b1, 5'd10, 1'b1, 32'hAA01, 5'd11, 1'b1, 32'hBB01);
    step();
    drive(1'b1, 5'd12, 1'b1, 32'hAA02, 5'd13, 1'b1, 32'hBB02);
    step();
    drive(1'b1, 5'd14, 1'b1, 32'hDEAD, 5'd15, 1'b1, 32'hBEEF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    tests_run++;
    if ({wb_if.valid, wb_if.wreg, mem_if.ready} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL flush_full: got valid=%b wreg=%b mem_ready=%b, required 0 00 1",
               wb_if.valid, wb_if.wreg, mem_if.ready);
    end
    drive(1'b1, 5'd16, 1'b1, 32'hAA03, 5'd17, 1'b1, 32'hBB03);
    step();
    drive(1'b1, 5'd18, 1'b1, 32'hDEAD, 5'd19, 1'b1, 32'hBEEF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    wb_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wb_if.valid !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL flush_dropped: got %0d valid cycles after flush, required 0", seen);
    end
    drive(1'b1, 5'd20, 1'b1, 32'h5A5A, 5'd21, 1'b1, 32'hA5A5);
    step();
    idle();
    tests_run++;
    if ({wb_if.valid, wb_if.wdata[31:0]} !== {1'b1, 32'h5A5A}) begin
      tests_failed++;
      $display("FAIL flush_recover: got valid=%b data0=%h, required 1 00005a5a",
               wb_if.valid, wb_if.wdata[31:0]);
    end
    step();
    check_drained("flush");
  endtask

`ifdef MEMWB_STATS_EN
  task automatic test_stats();
    wb_if.ready = 1'b0;
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    tests_run++;
    if ({stat_retired, stat_stall} !== 8'h00) begin
      tests_failed++;
      $display("FAIL stats_reset: got retired=%h stall=%h, required 0 0", stat_retired, stat_stall);
    end
    step();
    drive(1'b1, 5'd1, 1'b1, 32'h1, 5'd2, 1'b1, 32'h2);
    step();
    idle();
    for (int i = 0; i < 20; i++) step();
    tests_run++;
    if (stat_stall !== 4'hF) begin
      tests_failed++;
      $display("FAIL stats_stall_sat: got %h, required f", stat_stall);
    end
    wb_if.ready = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 32'h3, 5'd4, 1'b1, 32'h4);
    step();
    drive(1'b1, 5'd5, 1'b1, 32'h5, 5'd6, 1'b1, 32'h6);
    step();
    idle();
    step();
    step();
    tests_run++;
    if ({stat_retired, stat_stall} !== {4'd3, 4'hF}) begin
      tests_failed++;
      $display("FAIL stats_retired: got retired=%0d stall=%h, required 3 f", stat_retired, stat_stall);
    end
    check_drained("stats");
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_conflict();
    test_flush();
`ifdef MEMWB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
